// File: rtl/iterative_shift_unit_pkg.sv
// Shared definitions for the iterative shift unit: op encodings, FSM states and
// the op-validity helper used to treat reserved ops as zero-length operations.
package iterative_shift_unit_pkg;

    localparam int unsigned DefaultWidth  = 8;
    localparam int unsigned DefaultShamtW = 3;

    typedef enum logic [2:0] {
        OpSll = 3'b000,
        OpSrl = 3'b001,
        OpSra = 3'b010,
        OpRor = 3'b011,
        OpRol = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Encodings above OpRol are reserved and complete immediately with the operand unchanged.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op <= 3'(OpRol));
    endfunction

endpackage

// File: rtl/iterative_shift_unit_shift_step.sv
// Combinational single-bit shift/rotate step applied once per SHIFT-state cycle.
module iterative_shift_unit_shift_step
    import iterative_shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Select the one-position step for the captured op; reserved ops pass through.
    always_comb begin
        o_data = i_data;
        case (i_op)
            3'(OpSll): o_data = {i_data[WIDTH-2:0], 1'b0};
            3'(OpSrl): o_data = {1'b0, i_data[WIDTH-1:1]};
            3'(OpSra): o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
            3'(OpRor): o_data = {i_data[0], i_data[WIDTH-1:1]};
            3'(OpRol): o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
            default:   o_data = i_data;
        endcase
    end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shift/rotate engine: one bit position per clock behind a start/done
// handshake. Holds the FSM, the remaining-step counter and the operand/op registers.
module iterative_shift_unit
    import iterative_shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned SHAMT_W = DefaultShamtW
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [2:0]         i_op,
    input  logic [WIDTH-1:0]   i_in,
    input  logic [SHAMT_W-1:0] i_shift,
    output logic [WIDTH-1:0]   o_out,
    output logic               o_busy,
    output logic               o_done
);

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_out;
    logic [SHAMT_W-1:0] r_count;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   w_step;
    logic               w_ready;
    logic               w_accept;
    logic               w_has_work;

    // New requests are only taken when idle or in the final DONE cycle.
    assign w_ready    = (r_state == StIdle) || (r_state == StDone);
    assign w_accept   = w_ready && i_start;
    // Zero amounts and reserved ops skip the SHIFT state entirely.
    assign w_has_work = (i_shift != '0) && op_is_valid(i_op);

    iterative_shift_unit_shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .i_op   (r_op),
        .i_data (r_out),
        .o_data (w_step)
    );

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = w_has_work ? StShift : StDone;
                end
            end
            StShift: begin
                if (r_count == SHAMT_W'(1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (i_start) begin
                    w_state_next = w_has_work ? StShift : StDone;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: capture on accept, step and count down while shifting, hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out   <= '0;
            r_count <= '0;
            r_op    <= '0;
        end else if (w_accept) begin
            r_out   <= i_in;
            r_count <= w_has_work ? i_shift : '0;
            r_op    <= i_op;
        end else if (r_state == StShift) begin
            r_out   <= w_step;
            r_count <= r_count - SHAMT_W'(1);
        end
    end

    // Outputs decoded from the current state; BUSY and DONE are mutually exclusive.
    always_comb begin
        o_busy = (r_state == StShift);
        o_done = (r_state == StDone);
    end

    assign o_out = r_out;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit: expected results are pushed to a
// scoreboard queue when an op is issued and popped when DONE is observed.
module tb_iterative_shift_unit;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic [2:0] i_op;
    logic [7:0] i_in;
    logic [2:0] i_shift;
    logic [7:0] o_out;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    iterative_shift_unit #(
        .WIDTH   (8),
        .SHAMT_W (3)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_op    (i_op),
        .i_in    (i_in),
        .i_shift (i_shift),
        .o_out   (o_out),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    // Reference: whole-amount shift computed in one go, independent of the stepping RTL.
    function automatic logic [7:0] ref_shift(input logic [2:0] op, input logic [7:0] din,
                                             input int n);
        logic [15:0] dbl;
        logic [15:0] tmp;
        dbl = {din, din};
        case (op)
            3'b000:  return din << n;
            3'b001:  return din >> n;
            3'b010:  return 8'($signed(din) >>> n);
            3'b011:  begin tmp = dbl >> n; return tmp[7:0]; end
            3'b100:  begin tmp = dbl << n; return tmp[15:8]; end
            default: return din;
        endcase
    endfunction

    // Drive one request for a single cycle, then scramble the inputs to show they are not reused.
    task automatic issue(input logic [2:0] op, input logic [7:0] din, input logic [2:0] sh);
        @(negedge clk);
        i_start = 1'b1;
        i_op    = op;
        i_in    = din;
        i_shift = sh;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_op    = 3'($urandom_range(0, 7));
        i_in    = ~din;
        i_shift = 3'($urandom_range(0, 7));
    endtask

    // Wait (bounded) for DONE, counting BUSY cycles and noting any BUSY/DONE overlap.
    task automatic wait_done(output logic [7:0] got, output int busy_n, output logic overlap,
                             output logic timed_out);
        got       = 'x;
        busy_n    = 0;
        overlap   = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_busy && o_done) overlap = 1'b1;
            if (o_done) begin
                got       = o_out;
                timed_out = 1'b0;
                break;
            end
            if (o_busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_start = 1'b1;
        i_op    = 3'b000;
        i_in    = 8'hA5;
        i_shift = 3'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got %h want 00", o_out);
        end
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b want 0 0", o_busy, o_done);
        end
        i_start = 1'b0;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b out=%h want 0 0 00",
                     o_busy, o_done, o_out);
        end
    endtask

    task automatic test_ops();
        logic [2:0] ops[6]    = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b011};
        logic [2:0] amts[6]   = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd1, 3'd7};
        logic [7:0] spec_r[6] = '{8'b10001000, 8'b00010010, 8'b11100100,
                                  8'b11001000, 8'b00100011, 8'b00100011};
        logic [7:0] got;
        logic [7:0] exp;
        int         busy_n;
        logic       overlap;
        logic       tmo;
        for (int k = 0; k < 6; k++) begin
            exp = ref_shift(ops[k], 8'b10010001, int'(amts[k]));
            checks++;
            if (exp !== spec_r[k]) begin
                errors++;
                $display("FAIL model_vec%0d model=%b want %b", k, exp, spec_r[k]);
            end
            exp_q.push_back(exp);
            issue(ops[k], 8'b10010001, amts[k]);
            wait_done(got, busy_n, overlap, tmo);
            exp = exp_q.pop_front();
            checks++;
            if (tmo) begin
                errors++;
                $display("FAIL op%0d_timeout got no DONE want DONE", k);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL op%0d_result got %b want %b", k, got, exp);
            end
            checks++;
            if (busy_n !== int'(amts[k])) begin
                errors++;
                $display("FAIL op%0d_busy_cycles got %0d want %0d", k, busy_n, amts[k]);
            end
            checks++;
            if (overlap) begin
                errors++;
                $display("FAIL op%0d_overlap got busy&done=1 want 0", k);
            end
            @(negedge clk);
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_out !== exp) begin
                errors++;
                $display("FAIL op%0d_idle got done=%b busy=%b out=%b want 0 0 %b",
                         k, o_done, o_busy, o_out, exp);
            end
        end
    endtask

    task automatic test_zero_and_reserved();
        logic [2:0] ops[2]  = '{3'b000, 3'b111};
        logic [2:0] amts[2] = '{3'd0, 3'd5};
        logic [7:0] got;
        logic [7:0] exp;
        int         busy_n;
        logic       overlap;
        logic       tmo;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(8'b10010001);
            issue(ops[k], 8'b10010001, amts[k]);
            wait_done(got, busy_n, overlap, tmo);
            exp = exp_q.pop_front();
            checks++;
            if (tmo || busy_n !== 0) begin
                errors++;
                $display("FAIL zero%0d_latency got busy=%0d timeout=%b want 0 0", k, busy_n, tmo);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero%0d_result got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] got;
        logic [7:0] exp;
        int         busy_n;
        logic       overlap;
        logic       tmo;
        exp_q.push_back(ref_shift(3'b000, 8'b10010001, 3));
        issue(3'b000, 8'b10010001, 3'd3);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy got %b want 1", o_busy);
        end
        i_start = 1'b1;
        i_op    = 3'b001;
        i_in    = 8'hFF;
        i_shift = 3'd1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(got, busy_n, overlap, tmo);
        exp = exp_q.pop_front();
        checks++;
        if (tmo || got !== exp) begin
            errors++;
            $display("FAIL ignore_result got %b timeout=%b want %b", got, tmo, exp);
        end
        checks++;
        if (busy_n !== 2) begin
            errors++;
            $display("FAIL ignore_busy_cycles got %0d want 2", busy_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] exp;
        int         busy_n;
        logic       overlap;
        logic       tmo;
        logic       seen;
        exp_q.push_back(ref_shift(3'b100, 8'h91, 2));
        @(negedge clk);
        i_start = 1'b1;
        i_op    = 3'b100;
        i_in    = 8'h91;
        i_shift = 3'd2;
        seen    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        exp = exp_q.pop_front();
        checks++;
        if (!seen || o_out !== exp) begin
            errors++;
            $display("FAIL b2b_first got %h seen=%b want %h", o_out, seen, exp);
        end
        // START stays high through DONE; the second request is taken on the next edge.
        exp_q.push_back(ref_shift(3'b010, 8'h80, 1));
        i_op    = 3'b010;
        i_in    = 8'h80;
        i_shift = 3'd1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(got, busy_n, overlap, tmo);
        exp = exp_q.pop_front();
        checks++;
        if (tmo || got !== exp) begin
            errors++;
            $display("FAIL b2b_second got %h timeout=%b want %h", got, tmo, exp);
        end
        checks++;
        if (busy_n !== 1) begin
            errors++;
            $display("FAIL b2b_busy_cycles got %0d want 1", busy_n);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        logic [7:0] exp;
        int         busy_n;
        logic       overlap;
        logic       tmo;
        issue(3'b000, 8'b10010001, 3'd5);
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_out !== 8'h00 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got out=%h busy=%b done=%b want 00 0 0",
                     o_out, o_busy, o_done);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle got busy=%b done=%b want 0 0", o_busy, o_done);
        end
        exp_q.push_back(ref_shift(3'b001, 8'b10010001, 2));
        issue(3'b001, 8'b10010001, 3'd2);
        wait_done(got, busy_n, overlap, tmo);
        exp = exp_q.pop_front();
        checks++;
        if (tmo || got !== exp || busy_n !== 2) begin
            errors++;
            $display("FAIL after_abort got %h busy=%0d timeout=%b want %h busy=2",
                     got, busy_n, tmo, exp);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_zero_and_reserved();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
